// File: rtl/riscv_nn_defines.sv
// Shared types for the riscv_nn instruction fetch path.
package riscv_nn_defines;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned HALF_W  = 16;

    // Aligner position within the fetch stream.
    typedef enum logic [1:0] {
        ALIGNED    = 2'd0,
        MISALIGNED = 2'd1,
        BRANCH_MIS = 2'd2
    } aligner_state_e;

endpackage

// File: rtl/riscv_nn_instr_aligner.sv
// Turns word-aligned fetch data into one bit-0-aligned instruction per handshake,
// handling compressed code and halfword branch targets.
module riscv_nn_instr_aligner
    import riscv_nn_defines::*;
#(
    parameter logic [INSTR_W-1:0] RESET_ADDR = 32'h0000_0080
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid_i,
    input  logic [INSTR_W-1:0] fetch_rdata_i,
    output logic               fetch_ready_o,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_rdata_o,
    output logic [INSTR_W-1:0] instr_addr_o,
    input  logic               instr_ready_i,
    input  logic               branch_i,
    input  logic [INSTR_W-1:0] branch_addr_i
);

    aligner_state_e      state_q, state_d;
    logic [HALF_W-1:0]   hold_q, hold_d;
    logic [INSTR_W-1:0]  pc_q, pc_d;

    logic [HALF_W-1:0]   w_lo, w_hi;

    function automatic logic is_compressed(input logic [1:0] opc);
        return opc != 2'b11;
    endfunction

    assign w_lo         = fetch_rdata_i[HALF_W-1:0];
    assign w_hi         = fetch_rdata_i[INSTR_W-1:HALF_W];
    assign instr_addr_o = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ALIGNED;
            hold_q  <= '0;
            pc_q    <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pc_q    <= pc_d;
        end
    end

    // Output selection and next-state; registers only move on a completed transfer.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        pc_d          = pc_q;
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_rdata_o = fetch_rdata_i;

        unique case (state_q)
            ALIGNED: begin
                instr_valid_o = fetch_valid_i;
                fetch_ready_o = instr_ready_i;
                instr_rdata_o = fetch_rdata_i;
                if (fetch_valid_i && instr_ready_i) begin
                    if (is_compressed(w_lo[1:0])) begin
                        hold_d  = w_hi;
                        pc_d    = pc_q + 32'd2;
                        state_d = MISALIGNED;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                    end
                end
            end

            MISALIGNED: begin
                if (is_compressed(hold_q[1:0])) begin
                    // Buffered compressed instruction needs no new fetch word.
                    instr_valid_o = 1'b1;
                    instr_rdata_o = {16'h0000, hold_q};
                    if (instr_ready_i) begin
                        pc_d    = pc_q + 32'd2;
                        state_d = ALIGNED;
                    end
                end else begin
                    instr_valid_o = fetch_valid_i;
                    fetch_ready_o = instr_ready_i;
                    instr_rdata_o = {w_lo, hold_q};
                    if (fetch_valid_i && instr_ready_i) begin
                        hold_d = w_hi;
                        pc_d   = pc_q + 32'd4;
                    end
                end
            end

            BRANCH_MIS: begin
                if (is_compressed(w_hi[1:0])) begin
                    instr_valid_o = fetch_valid_i;
                    fetch_ready_o = instr_ready_i;
                    instr_rdata_o = {16'h0000, w_hi};
                    if (fetch_valid_i && instr_ready_i) begin
                        pc_d    = pc_q + 32'd2;
                        state_d = ALIGNED;
                    end
                end else begin
                    // Swallow the word to pick up the first half of the target.
                    fetch_ready_o = fetch_valid_i;
                    if (fetch_valid_i) begin
                        hold_d  = w_hi;
                        state_d = MISALIGNED;
                    end
                end
            end

            default: begin
                state_d = ALIGNED;
            end
        endcase

        if (branch_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
            pc_d          = {branch_addr_i[INSTR_W-1:1], 1'b0};
            hold_d        = '0;
            state_d       = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
        end

        if (rst) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_nn_instr_aligner.sv
// Directed and randomized checks of the instruction aligner against a halfword-stream model.
module tb_riscv_nn_instr_aligner;

    logic        clk;
    logic        rst;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        instr_ready_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    int checks = 0;
    int errors = 0;
    int transfers = 0;

    logic [31:0] mem [64];
    logic [31:0] model_pc;
    logic [31:0] fetch_addr;

    riscv_nn_instr_aligner #(.RESET_ADDR(32'h0000_0080)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid_i (fetch_valid_i),
        .fetch_rdata_i (fetch_rdata_i),
        .fetch_ready_o (fetch_ready_o),
        .instr_valid_o (instr_valid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .instr_ready_i (instr_ready_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge, then settle before sampling.
    task automatic drive(input logic fv, input logic [31:0] w, input logic rdy,
                         input logic br, input logic [31:0] ba);
        @(negedge clk);
        fetch_valid_i = fv;
        fetch_rdata_i = w;
        instr_ready_i = rdy;
        branch_i      = br;
        branch_addr_i = ba;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] data, input logic [31:0] addr);
        chk({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
        chk({tag, "_data"}, instr_rdata_o, data);
        chk({tag, "_addr"}, instr_addr_o, addr);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst           = 1'b1;
        fetch_valid_i = 1'b1;
        instr_ready_i = 1'b1;
        branch_i      = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_fready", 32'(fetch_ready_o), 32'd0);
        chk("rst_addr", instr_addr_o, 32'h0000_0080);
        fetch_valid_i = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    // Reference: the instruction at PC p is read straight from the halfword stream.
    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] word;
        word = mem[a[7:2]];
        return a[1] ? word[31:16] : word[15:0];
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] p);
        logic [15:0] lo;
        lo = hw(p);
        if (lo[1:0] != 2'b11 && p[1]) return {16'h0000, lo};
        return {hw(p + 32'd2), lo};
    endfunction

    function automatic logic [31:0] instr_len(input logic [31:0] p);
        logic [15:0] lo;
        lo = hw(p);
        return (lo[1:0] != 2'b11) ? 32'd2 : 32'd4;
    endfunction

    initial begin
        logic        br;
        logic [31:0] target;

        rst           = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0000_0013;
        instr_ready_i = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        #1;
        chk("init_valid", 32'(instr_valid_o), 32'd0);
        chk("init_fready", 32'(fetch_ready_o), 32'd0);
        chk("init_addr", instr_addr_o, 32'h0000_0080);
        fetch_valid_i = 1'b0;
        @(negedge clk);
        #3;
        rst = 1'b0;

        // Aligned 32-bit run
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
            expect_out("al32", 32'h0000_0013, 32'h80 + 32'(4 * i));
            chk("al32_fready", 32'(fetch_ready_o), 32'd1);
        end

        // Two compressed instructions in one word
        reset_pulse();
        drive(1'b1, 32'h4501_4505, 1'b1, 1'b0, 32'h0);
        expect_out("c2_first", 32'h4501_4505, 32'h80);
        chk("c2_fready0", 32'(fetch_ready_o), 32'd1);
        drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        expect_out("c2_second", 32'h0000_4501, 32'h82);
        chk("c2_fready1", 32'(fetch_ready_o), 32'd0);
        drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        chk("c2_idle", 32'(instr_valid_o), 32'd0);

        // 32-bit instruction straddling two words
        reset_pulse();
        drive(1'b1, 32'h0513_4505, 1'b1, 1'b0, 32'h0);
        expect_out("st_c", 32'h0513_4505, 32'h80);
        drive(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
        expect_out("st_32", 32'h0000_0513, 32'h82);
        chk("st_fready", 32'(fetch_ready_o), 32'd1);
        drive(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        expect_out("st_next", 32'h0000_0000, 32'h86);

        // Misaligned branch target, compressed upper half
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0102);
        chk("br_valid", 32'(instr_valid_o), 32'd0);
        chk("br_fready", 32'(fetch_ready_o), 32'd0);
        drive(1'b1, 32'h4505_0001, 1'b1, 1'b0, 32'h0);
        expect_out("bm_c", 32'h0000_4505, 32'h102);
        chk("bm_c_fready", 32'(fetch_ready_o), 32'd1);

        // Misaligned branch target, 32-bit upper half (bit 0 of target ignored)
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0103);
        chk("br2_valid", 32'(instr_valid_o), 32'd0);
        drive(1'b1, 32'h0013_4505, 1'b1, 1'b0, 32'h0);
        chk("bm32_valid", 32'(instr_valid_o), 32'd0);
        chk("bm32_fready", 32'(fetch_ready_o), 32'd1);
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        expect_out("bm32_out", 32'h5678_0013, 32'h102);

        // Stall keeps output and PC stable; branch wins during the stall
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
            expect_out("stall", 32'h0000_1234, 32'h106);
        end
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h0000_0200);
        chk("stall_br_valid", 32'(instr_valid_o), 32'd0);
        chk("stall_br_fready", 32'(fetch_ready_o), 32'd0);
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        expect_out("after_br", 32'h0000_0013, 32'h200);

        // Reset while misaligned
        drive(1'b1, 32'h0013_4505, 1'b1, 1'b0, 32'h0);
        expect_out("pre_rst", 32'h0013_4505, 32'h204);
        reset_pulse();
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        expect_out("post_rst", 32'h0000_0013, 32'h80);

        // PC wrap
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_br_valid", 32'(instr_valid_o), 32'd0);
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        expect_out("wrap_last", 32'h0000_0013, 32'hFFFF_FFFC);
        drive(1'b1, 32'h0000_0017, 1'b1, 1'b0, 32'h0);
        expect_out("wrap_zero", 32'h0000_0017, 32'h0000_0000);

        // Randomized instruction stream against the halfword model
        for (int i = 0; i < 64; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 1) == 0) r[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) r[17:16] = 2'b11;
            mem[i] = r;
        end
        model_pc   = 32'h0;
        fetch_addr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            br     = (cyc == 0) || ($urandom_range(0, 40) == 0);
            target = $urandom;
            drive(($urandom_range(0, 3) != 0), mem[fetch_addr[7:2]],
                  ($urandom_range(0, 3) != 0), br, target);
            if (br) begin
                chk("rnd_br_valid", 32'(instr_valid_o), 32'd0);
                model_pc   = {target[31:1], 1'b0};
                fetch_addr = {target[31:2], 2'b00};
            end else begin
                if (instr_valid_o) begin
                    chk("rnd_addr", instr_addr_o, model_pc);
                    chk("rnd_data", instr_rdata_o, exp_data(model_pc));
                    if (instr_ready_i) begin
                        model_pc = model_pc + instr_len(model_pc);
                        transfers++;
                    end
                end
                if (fetch_valid_i && fetch_ready_o) fetch_addr = fetch_addr + 32'd4;
            end
        end
        chk("rnd_progress", 32'(transfers > 500), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
